// File: rtl/slv_i2c_reg_bank.sv
// Register bank behind an I2C slave: pointer byte, then auto-incrementing writes, plus a registered local read port.
// Optional SLV_I2C_REG_IRQ_EN adds O_IRQ, a one-cycle pulse at STOP when the transaction wrote anything.
module slv_i2c_reg_bank #(
   parameter int                 DATA_SZ  = 8,
   parameter logic [DATA_SZ-2:0] SLV_ADDR = 7'h3C,
   parameter int                 REG_NUM  = 16,
   parameter int                 PTR_SZ   = 4
) (
   input  logic               CLK,
   input  logic               RST_n,
   input  logic [DATA_SZ-2:0] I_ADDR_SLV,
   input  logic               I_RW,
   input  logic [DATA_SZ-1:0] I_DATA_RD,
   input  logic               I_BYTE_VLD,
   input  logic               I_BUSY,
   output logic               O_ACK,
   output logic               O_WR_STB,
   output logic [PTR_SZ-1:0]  O_WR_ADDR,
   output logic [DATA_SZ-1:0] O_WR_DATA,
   input  logic [PTR_SZ-1:0]  I_RD_ADDR,
   output logic [DATA_SZ-1:0] O_RD_DATA,
   output logic [PTR_SZ-1:0]  O_PTR
`ifdef SLV_I2C_REG_IRQ_EN
   ,
   output logic               O_IRQ
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_PTR, ST_DATA, ST_IGNORE} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_ack;
   logic                 w_ack_nxt;
   logic [PTR_SZ-1:0]    r_ptr;
   logic [PTR_SZ-1:0]    w_ptr_nxt;
   logic [PTR_SZ-1:0]    w_ptr_inc;
   logic                 w_wr_en;
   logic                 w_ptr_ok;
   logic                 w_rd_ok;
   logic                 r_armed;
   logic                 r_wr_stb;
   logic [PTR_SZ-1:0]    r_wr_addr;
   logic [DATA_SZ-1:0]   r_wr_data;
   logic [DATA_SZ-1:0]   r_rd_data;
   logic [DATA_SZ-1:0]   r_regs [REG_NUM];

   assign w_ptr_ok  = 32'(I_DATA_RD) < 32'(REG_NUM);
   assign w_rd_ok   = 32'(I_RD_ADDR) < 32'(REG_NUM);
   assign w_ptr_inc = (r_ptr == PTR_SZ'(REG_NUM - 1)) ? '0 : r_ptr + PTR_SZ'(1);

   always_ff @(posedge CLK) begin
      if (!RST_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_ack_nxt   = r_ack;
      w_ptr_nxt   = r_ptr;
      w_wr_en     = 1'b0;
      if (!I_BUSY) begin
         // STOP wins over a byte arriving in the same cycle.
         w_state_nxt = ST_IDLE;
         w_ack_nxt   = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // r_armed is clear only when reset released mid-transaction.
               if (!r_armed) begin
                  w_state_nxt = ST_IGNORE;
                  w_ack_nxt   = 1'b0;
               end else if (I_BYTE_VLD) begin
                  if (I_ADDR_SLV == SLV_ADDR && !I_RW) begin
                     w_state_nxt = ST_PTR;
                     w_ack_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = ST_IGNORE;
                     w_ack_nxt   = 1'b0;
                  end
               end
            end
            ST_PTR: begin
               if (I_BYTE_VLD) begin
                  if (w_ptr_ok) begin
                     w_ptr_nxt   = I_DATA_RD[PTR_SZ-1:0];
                     w_state_nxt = ST_DATA;
                     w_ack_nxt   = 1'b1;
                  end else begin
                     w_state_nxt = ST_IGNORE;
                     w_ack_nxt   = 1'b0;
                  end
               end
            end
            ST_DATA: begin
               if (I_BYTE_VLD) begin
                  w_wr_en   = 1'b1;
                  w_ptr_nxt = w_ptr_inc;
                  w_ack_nxt = 1'b1;
               end
            end
            ST_IGNORE: w_ack_nxt = 1'b0;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so a same-cycle read sees the old value.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_ack     <= 1'b0;
         r_ptr     <= '0;
         r_armed   <= 1'b0;
         r_wr_stb  <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_rd_data <= '0;
         // NOTE: the register file is reset because its contents are architecturally visible.
         for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
      end else begin
         r_ack    <= w_ack_nxt;
         r_ptr    <= w_ptr_nxt;
         r_wr_stb <= w_wr_en;
         if (!I_BUSY) r_armed <= 1'b1;
         if (w_wr_en) begin
            r_wr_addr     <= r_ptr;
            r_wr_data     <= I_DATA_RD;
            r_regs[r_ptr] <= I_DATA_RD;
         end
         r_rd_data <= w_rd_ok ? r_regs[I_RD_ADDR] : '0;
      end
   end

   assign O_ACK     = r_ack;
   assign O_WR_STB  = r_wr_stb;
   assign O_WR_ADDR = r_wr_addr;
   assign O_WR_DATA = r_wr_data;
   assign O_RD_DATA = r_rd_data;
   assign O_PTR     = r_ptr;

`ifdef SLV_I2C_REG_IRQ_EN
   logic r_busy_q;
   logic r_dirty;
   logic r_irq;
   logic w_busy_fall;

   assign w_busy_fall = r_busy_q & ~I_BUSY;

   // A strobe coinciding with the busy fall belongs to the finishing transaction.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_busy_q <= 1'b0;
         r_dirty  <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_busy_q <= I_BUSY;
         r_irq    <= w_busy_fall & (r_dirty | r_wr_stb);
         r_dirty  <= w_busy_fall ? 1'b0 : (r_dirty | r_wr_stb);
      end
   end

   assign O_IRQ = r_irq;
`endif

endmodule

// File: doc/slv_i2c_reg_bank.md
Name: slv_i2c_reg_bank

Overview:
- Application-side register bank directly downstream of the I2C slave top. Consumes its received address, R/W bit, data bytes and busy flag; returns the ACK/NACK decision that drives the slave's I_ACK input.
- Protocol: first data byte after the address is a register pointer. Following bytes are written to consecutive registers.
- Registers are readable by local logic through a registered read port.

Parameters:
- DATA_SZ, 8, data width.
- SLV_ADDR, 7'h3C, own 7-bit I2C address.
- REG_NUM, 16, number of registers, 2..2**PTR_SZ.
- PTR_SZ, 4, pointer width.

Ports:
- CLK  in  1  system clock 50 MHz
- RST_n  in  1  synchronous active-low reset
- I_ADDR_SLV  in  DATA_SZ-1  received slave address
- I_RW  in  1  received R/W bit
- I_DATA_RD  in  DATA_SZ  received data byte
- I_BYTE_VLD  in  1  one-cycle pulse per received byte (address byte first); I_ADDR_SLV/I_RW/I_DATA_RD valid in that cycle
- I_BUSY  in  1  high between START and STOP
- O_ACK  out  1  1 = ACK next byte, 0 = NACK; feeds slave I_ACK
- O_WR_STB  out  1  one-cycle register-write pulse
- O_WR_ADDR  out  PTR_SZ  written register index
- O_WR_DATA  out  DATA_SZ  written value
- I_RD_ADDR  in  PTR_SZ  local read index
- O_RD_DATA  out  DATA_SZ  local read data
- O_PTR  out  PTR_SZ  current pointer

Behaviour:
- All state is synchronous to CLK; reset is sampled on the CLK edge only.
- Reset values: all registers 0, pointer 0, O_ACK 0, O_WR_STB 0, O_WR_ADDR 0, O_WR_DATA 0, O_RD_DATA 0. State after reset is IDLE.
- FSM states: IDLE, PTR, DATA, IGNORE. Transitions fire only on I_BYTE_VLD, except the busy rules below.
- IDLE on byte:
  - I_ADDR_SLV==SLV_ADDR and I_RW==0: O_ACK<=1, go PTR.
  - Address mismatch, or I_RW==1 (reads not served): O_ACK<=0, go IGNORE.
- PTR on byte:
  - I_DATA_RD<REG_NUM: pointer<=I_DATA_RD[PTR_SZ-1:0], O_ACK<=1, go DATA.
  - Otherwise: O_ACK<=0, pointer unchanged, go IGNORE.
- DATA on byte:
  - reg[pointer]<=I_DATA_RD; O_WR_STB=1 for one cycle with O_WR_ADDR=pointer (pre-increment) and O_WR_DATA=I_DATA_RD.
  - Pointer<=pointer+1, wrapping from REG_NUM-1 to 0. O_ACK stays 1.
- IGNORE: all bytes are dropped and O_ACK held 0.
- Latency: O_ACK and the write become visible 1 cycle after I_BYTE_VLD; O_ACK is then held until the next update.
- I_BUSY low: from any state, go IDLE next cycle and set O_ACK<=1 so the next address byte can be ACKed. Pointer is retained across transactions.
- I_BYTE_VLD in the same cycle as I_BUSY low: byte is ignored; STOP wins.
- Reset deasserted while I_BUSY=1: enter IGNORE instead of IDLE, so a mid-transaction byte is never taken as an address. Return to IDLE on I_BUSY low.
- Repeated START is not distinguished: bytes continue in the current state.
- Read port: O_RD_DATA<=reg[I_RD_ADDR] each cycle, 1-cycle latency.
  - I_RD_ADDR>=REG_NUM returns 0.
  - Read and write of the same index in one cycle returns the old value.
- O_PTR reflects the pointer register directly.

Optional Feature:
- Macro: SLV_I2C_REG_IRQ_EN.
- Defined: adds output O_IRQ (1 bit, reset 0) and an internal dirty flag.
  - Dirty flag is set by any O_WR_STB and cleared at the I_BUSY falling edge.
  - O_IRQ pulses high for exactly one cycle at that falling edge if the flag was set.
  - A write strobe coinciding with the busy fall counts toward the IRQ for that transaction.
- Undefined: no O_IRQ port and no flag logic.

Test Plan:
- Write transaction: addr 0x3C/W, ptr 0x02, data 0xA5, 0x5A, then STOP.
  - Required: O_ACK=1 after each byte; strobes (2,A5) then (3,5A); O_PTR=4; reading index 3 gives 0x5A one cycle later.
- Address 0x3D/W with two data bytes.
  - Required: O_ACK=0 after the address byte; no O_WR_STB; registers unchanged; O_ACK=1 again after STOP.
- Pointer 0x10 with REG_NUM=16.
  - Required: NACK; pointer unchanged; following data byte 0x11 dropped with no strobe.
- Wrap-around: ptr 0x0F, data 0x01, 0x02.
  - Required: writes to reg15=0x01 and reg0=0x02; O_PTR=1.
- Reset mid-transaction: assert RST_n=0 for 2 cycles after the ptr byte while I_BUSY=1, then send byte 0x78.
  - Required: NACK and no write; after STOP, address 0x3C/W is ACKed normally.
- With SLV_I2C_REG_IRQ_EN defined:
  - Write transaction: one O_IRQ pulse at STOP.
  - Address-only transaction: no O_IRQ.
